// File: rtl/msg_comm_pkg.sv
// Shared constants for the message transmit arbiter: FSM encodings, byte width, default frame length.
package msg_comm_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned MAX_LEN_DEF = 2048;
    localparam int unsigned CNT_W       = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first active request at or after the pointer, wrapping to 0; one-hot result.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // Walk the requesters in priority order starting at the pointer
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = IDX_W'((32'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msg_tx_arbiter.sv
// Byte-stream arbiter feeding one serialiser: round-robin frame grant, MAX_LEN truncation,
// forced idle gap between frames. Optional mid-frame stall abort when MSG_ARB_TIMEOUT_EN is defined.
module msg_tx_arbiter
    import msg_comm_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned MAX_LEN        = MAX_LEN_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        src_vld_i,
    input  logic [NUM_REQ*BYTE_W-1:0] src_data_i,
    input  logic [NUM_REQ-1:0]        src_last_i,
    output logic [NUM_REQ-1:0]        src_ready_o,
    output logic                      msg_tx_vld_o,
    output logic [BYTE_W-1:0]         msg_tx_data_o,
    output logic                      msg_tx_last_o,
    input  logic                      msg_tx_ready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      len_err_o,
    output logic                      abort_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [1:0]         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic               r_len_err, w_len_err_nxt;

    logic [NUM_REQ-1:0] w_rr_grant;
    logic [IDX_W-1:0]   w_rr_idx;
    logic               w_xfer;
    logic               w_own_vld;
    logic               w_own_last;
    logic [BYTE_W-1:0]  w_own_data;
    logic               w_at_max;
    logic               w_trunc;
    logic               w_beat;
    logic               w_end_frame;

`ifdef MSG_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [STALL_W-1:0] r_stall, w_stall_nxt;
    logic               r_abort, w_abort_nxt;
    assign abort_o = r_abort;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign abort_o          = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req   (src_vld_i),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant)
    );

    // One-hot round-robin result to requester index
    always_comb begin
        w_rr_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_rr_grant[i]) w_rr_idx = IDX_W'(i);
        end
    end

    // Select the owner's stream and route the serialiser handshake back to it only
    always_comb begin
        w_own_vld   = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        src_ready_o = '0;
        grant_o     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_vld      = src_vld_i[i];
                w_own_last     = src_last_i[i];
                w_own_data     = src_data_i[i*BYTE_W +: BYTE_W];
                src_ready_o[i] = w_xfer & msg_tx_ready_i;
                grant_o[i]     = w_xfer;
            end
        end
    end

    assign w_xfer        = (r_state == ST_XFER);
    assign w_at_max      = (r_cnt == CNT_W'(MAX_LEN - 1));
    assign w_trunc       = w_at_max & ~w_own_last;
    assign msg_tx_vld_o  = w_xfer & w_own_vld;
    assign msg_tx_data_o = w_xfer ? w_own_data : '0;
    assign msg_tx_last_o = w_xfer & (w_own_last | w_at_max);
    assign w_beat        = msg_tx_vld_o & msg_tx_ready_i;
    assign len_err_o     = r_len_err;

    // Next-state logic: grant in IDLE, count beats in XFER, hold idle for the gap
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gap_nxt     = r_gap;
        w_len_err_nxt = 1'b0;
        w_end_frame   = 1'b0;
`ifdef MSG_ARB_TIMEOUT_EN
        w_stall_nxt   = r_stall;
        w_abort_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|src_vld_i) begin
                    w_owner_nxt = w_rr_idx;
                    w_ptr_nxt   = (w_rr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_rr_idx + 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_XFER;
`ifdef MSG_ARB_TIMEOUT_EN
                    w_stall_nxt = '0;
`endif
                end
            end
            ST_XFER: begin
                if (w_beat) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (msg_tx_last_o) begin
                        w_end_frame   = 1'b1;
                        w_len_err_nxt = w_trunc;
                    end
                end
`ifdef MSG_ARB_TIMEOUT_EN
                if (w_own_vld) begin
                    w_stall_nxt = '0;
                end else if (r_stall == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                    w_end_frame = 1'b1;
                    w_abort_nxt = 1'b1;
                end else begin
                    w_stall_nxt = r_stall + 1'b1;
                end
`endif
                if (w_end_frame) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_W'(GAP_CYCLES - 1)) w_state_nxt = ST_IDLE;
                else                                 w_gap_nxt   = r_gap + 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_len_err <= 1'b0;
`ifdef MSG_ARB_TIMEOUT_EN
            r_stall   <= '0;
            r_abort   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap     <= w_gap_nxt;
            r_len_err <= w_len_err_nxt;
`ifdef MSG_ARB_TIMEOUT_EN
            r_stall   <= w_stall_nxt;
            r_abort   <= w_abort_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Bench for msg_tx_arbiter: frame-level reference model checked every cycle, plus literal
// expectations on the beat/frame logs. Timeout scenario active when MSG_ARB_TIMEOUT_EN is defined.
module tb_msg_tx_arbiter;

    localparam int NR   = 4;
    localparam int GAP  = 16;
    localparam int MLEN = 2048;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   src_vld_i;
    logic [NR*8-1:0] src_data_i;
    logic [NR-1:0]   src_last_i;
    logic [NR-1:0]   src_ready_o;
    logic            msg_tx_vld_o;
    logic [7:0]      msg_tx_data_o;
    logic            msg_tx_last_o;
    logic            msg_tx_ready_i;
    logic [NR-1:0]   grant_o;
    logic            len_err_o;
    logic            abort_o;

    msg_tx_arbiter #(
        .NUM_REQ(NR), .GAP_CYCLES(GAP), .MAX_LEN(MLEN), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_vld_i(src_vld_i), .src_data_i(src_data_i), .src_last_i(src_last_i),
        .src_ready_o(src_ready_o),
        .msg_tx_vld_o(msg_tx_vld_o), .msg_tx_data_o(msg_tx_data_o), .msg_tx_last_o(msg_tx_last_o),
        .msg_tx_ready_i(msg_tx_ready_i),
        .grant_o(grant_o), .len_err_o(len_err_o), .abort_o(abort_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- source byte queues ----------------
    logic [8:0]    sbuf [NR][8192];
    int            shead [NR] = '{default: 0};
    int            stail [NR] = '{default: 0};
    logic [NR-1:0] acc;

    task automatic push(input int s, input logic [7:0] d, input bit l);
        sbuf[s][stail[s]] = {l, d};
        stail[s]++;
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int s = 0; s < NR; s++) if (shead[s] != stail[s]) e = 1'b0;
        return e;
    endfunction

    // Sources: pop on accepted handshake, present next byte just after the edge
    initial begin
        src_vld_i  = '0;
        src_data_i = '0;
        src_last_i = '0;
        forever begin
            @(negedge clk);
            acc = src_vld_i & src_ready_o;
            @(posedge clk);
            #1;
            for (int s = 0; s < NR; s++) begin
                if (acc[s] && shead[s] < stail[s]) shead[s]++;
                if (shead[s] < stail[s]) begin
                    src_vld_i[s]       = 1'b1;
                    src_data_i[s*8+:8] = sbuf[s][shead[s]][7:0];
                    src_last_i[s]      = sbuf[s][shead[s]][8];
                end else begin
                    src_vld_i[s]       = 1'b0;
                    src_data_i[s*8+:8] = 8'h00;
                    src_last_i[s]      = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    int  m_mode = 0;      // 0 idle, 1 transferring, 2 gap
    int  m_owner = 0, m_ptr = 0, m_beats = 0, m_gap_left = 0, m_stall = 0;
    bit  m_len_err = 0, m_abort = 0;
    int  n_lenerr = 0, n_abort = 0;

    logic [7:0] lg_data  [8192];
    bit         lg_last  [8192];
    int         lg_owner [8192];
    int         lg_cyc   [8192];
    int         lg_n = 0;
    int         fr_owner [64];
    int         fr_cyc   [64];
    int         fr_n = 0;

    bit         e_xfer, e_vld, e_last, e_beat, found, nle, nab, to_gap;
    logic [7:0] e_data;
    logic [3:0] e_ready, e_grant;
    int         k, nown;

    // Per-cycle compare, then advance the model across the coming edge
    always @(negedge clk) begin
        cyc++;
        e_xfer  = (m_mode == 1);
        e_vld   = e_xfer && src_vld_i[m_owner];
        e_data  = e_xfer ? 8'(src_data_i >> (m_owner * 8)) : 8'h00;
        e_last  = e_xfer && (src_last_i[m_owner] || m_beats == MLEN - 1);
        e_ready = e_xfer ? 4'(32'(msg_tx_ready_i) << m_owner) : 4'h0;
        e_grant = e_xfer ? 4'(1 << m_owner) : 4'h0;
        check("tx_vld",  32'(msg_tx_vld_o),  32'(e_vld));
        check("tx_data", 32'(msg_tx_data_o), 32'(e_data));
        check("tx_last", 32'(msg_tx_last_o), 32'(e_last));
        check("ready",   32'(src_ready_o),   32'(e_ready));
        check("grant",   32'(grant_o),       32'(e_grant));
        check("len_err", 32'(len_err_o),     32'(m_len_err));
        check("abort",   32'(abort_o),       32'(m_abort));

        e_beat = e_vld && msg_tx_ready_i;
        nle    = 1'b0;
        nab    = 1'b0;
        to_gap = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_ptr = 0; m_beats = 0; m_stall = 0; m_owner = 0;
        end else begin
            case (m_mode)
                0: if (src_vld_i != '0) begin
                    found = 1'b0;
                    nown  = 0;
                    for (int i = 0; i < NR; i++) begin
                        k = (m_ptr + i) % NR;
                        if (!found && src_vld_i[k]) begin
                            found = 1'b1;
                            nown  = k;
                        end
                    end
                    m_owner = nown;
                    m_ptr   = (nown + 1) % NR;
                    m_beats = 0;
                    m_stall = 0;
                    m_mode  = 1;
                    if (fr_n < 64) begin
                        fr_owner[fr_n] = nown;
                        fr_cyc[fr_n]   = cyc + 1;
                        fr_n++;
                    end
                end
                1: begin
                    if (e_beat) begin
                        lg_data[lg_n]  = e_data;
                        lg_last[lg_n]  = e_last;
                        lg_owner[lg_n] = m_owner;
                        lg_cyc[lg_n]   = cyc;
                        lg_n++;
                        m_beats++;
                        if (e_last) begin
                            nle    = !src_last_i[m_owner];
                            to_gap = 1'b1;
                        end
                    end
`ifdef MSG_ARB_TIMEOUT_EN
                    if (src_vld_i[m_owner]) m_stall = 0;
                    else begin
                        m_stall++;
                        if (m_stall == TO) begin
                            nab    = 1'b1;
                            to_gap = 1'b1;
                        end
                    end
`endif
                    if (to_gap) begin
                        m_gap_left = GAP;
                        m_mode     = (GAP == 0) ? 0 : 2;
                    end
                end
                default: begin
                    m_gap_left--;
                    if (m_gap_left == 0) m_mode = 0;
                end
            endcase
        end
        m_len_err = rst_n && nle;
        m_abort   = rst_n && nab;
        if (m_len_err) n_lenerr++;
        if (m_abort)   n_abort++;
    end

    // ---------------- directed sequence ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int  n = 0;
        bit  ok = 1'b0;
        tick();
        while (!ok && n < budget) begin
            ok = all_empty() && (m_mode == 0);
            if (!ok) begin
                tick();
                n++;
            end
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    task automatic wait_beats(input int target, input int budget, input string nm);
        int n = 0;
        while (lg_n < target && n < budget) begin
            tick();
            n++;
        end
        check(nm, 32'(lg_n >= target), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int s = 0; s < NR; s++) shead[s] = stail[s];
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int lb, fb, le0, ab0;

    initial begin
        rst_n          = 1'b0;
        msg_tx_ready_i = 1'b1;
        repeat (3) tick();
        check("rst_grant",  32'(grant_o),      32'h0);
        check("rst_vld",    32'(msg_tx_vld_o), 32'h0);
        check("rst_ready",  32'(src_ready_o),  32'h0);
        check("rst_lenerr", 32'(len_err_o),    32'h0);
        check("rst_abort",  32'(abort_o),      32'h0);
        rst_n = 1'b1;
        tick();

        // Three-byte frame from src0
        lb = lg_n; le0 = n_lenerr;
        push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        wait_done(100, "A_done");
        check("A_cnt", 32'(lg_n - lb), 32'd3);
        check("A_d0", 32'(lg_data[lb]),   32'hA1);
        check("A_d1", 32'(lg_data[lb+1]), 32'hA2);
        check("A_d2", 32'(lg_data[lb+2]), 32'hA3);
        check("A_lasts", 32'({lg_last[lb], lg_last[lb+1], lg_last[lb+2]}), 32'b001);
        check("A_lenerr", 32'(n_lenerr - le0), 32'd0);

        // Round robin: src1+src2 together, then src1+src3 together
        do_reset();
        lb = lg_n; fb = fr_n;
        push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
        wait_done(200, "B_done1");
        push(1, 8'hD0, 1'b1);
        push(3, 8'hE0, 1'b1);
        wait_done(200, "B_done2");
        check("B_frames", 32'(fr_n - fb), 32'd4);
        check("B_own0", 32'(fr_owner[fb]),   32'd1);
        check("B_own1", 32'(fr_owner[fb+1]), 32'd2);
        check("B_own2", 32'(fr_owner[fb+2]), 32'd3);
        check("B_own3", 32'(fr_owner[fb+3]), 32'd1);
        check("B_gap_to_grant", 32'(fr_cyc[fb+1] - lg_cyc[lb+1]), 32'(GAP + 2));
        check("B_d4", 32'(lg_data[lb+4]), 32'hE0);
        check("B_d5", 32'(lg_data[lb+5]), 32'hD0);

        // Serialiser back-pressure mid-frame
        lb = lg_n;
        for (int i = 0; i < 6; i++) push(0, 8'(8'h10 + i), i == 5);
        wait_beats(lb + 2, 50, "C_start");
        msg_tx_ready_i = 1'b0;
        tick();
        check("C_hold_ready", 32'(src_ready_o),  32'h0);
        check("C_hold_vld",   32'(msg_tx_vld_o), 32'h1);
        check("C_hold_grant", 32'(grant_o),      32'h1);
        repeat (4) tick();
        msg_tx_ready_i = 1'b1;
        wait_done(100, "C_done");
        check("C_cnt", 32'(lg_n - lb), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("C_data", 32'(lg_data[lb+i]), 32'(8'h10 + i));
            check("C_last", 32'(lg_last[lb+i]), 32'(i == 5));
        end

        // 2050 bytes: truncation at MAX_LEN, remaining two bytes form a new frame
        lb = lg_n; fb = fr_n; le0 = n_lenerr;
        for (int i = 0; i < MLEN + 2; i++) push(0, 8'(i), i == MLEN + 1);
        wait_done(MLEN + 200, "D_done");
        check("D_cnt", 32'(lg_n - lb), 32'(MLEN + 2));
        check("D_last_2048", 32'(lg_last[lb+MLEN-1]), 32'd1);
        check("D_data_2048", 32'(lg_data[lb+MLEN-1]), 32'hFF);
        check("D_last_2049", 32'(lg_last[lb+MLEN]),   32'd0);
        check("D_last_2050", 32'(lg_last[lb+MLEN+1]), 32'd1);
        check("D_lenerr", 32'(n_lenerr - le0), 32'd1);
        check("D_frames", 32'(fr_n - fb), 32'd2);

        // Owner stalls after two bytes
        lb = lg_n; ab0 = n_abort;
        push(2, 8'hE0, 1'b0); push(2, 8'hE1, 1'b0);
        wait_beats(lb + 2, 50, "E_start");
        repeat (20) tick();
`ifdef MSG_ARB_TIMEOUT_EN
        check("E_abort", 32'(n_abort - ab0), 32'd1);
        check("E_grant", 32'(grant_o), 32'h0);
`else
        check("E_abort", 32'(n_abort - ab0), 32'd0);
        check("E_grant", 32'(grant_o), 32'h4);
`endif
        push(2, 8'hE2, 1'b1);
        wait_done(100, "E_done");
        check("E_last", 32'(lg_last[lg_n-1]), 32'd1);

        // Reset mid-frame abandons the frame
        lb = lg_n;
        for (int i = 0; i < 4; i++) push(1, 8'(8'h31 + i), i == 3);
        wait_beats(lb + 2, 50, "F_start");
        rst_n = 1'b0;
        for (int s = 0; s < NR; s++) shead[s] = stail[s];
        tick();
        check("F_grant", 32'(grant_o),       32'h0);
        check("F_vld",   32'(msg_tx_vld_o),  32'h0);
        check("F_ready", 32'(src_ready_o),   32'h0);
        check("F_last",  32'(msg_tx_last_o), 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("F_cnt",      32'(lg_n - lb),      32'd2);
        check("F_no_last",  32'(lg_last[lb+1]),  32'd0);
        check("F_idle",     32'(grant_o),        32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
